icache_direct: RTL and testbench

- Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port.
- Serves fetches from an internal frame array in the same cycle when the address hits.
- On a miss, runs a single-word fill from memory and stalls fetch by holding ihit low until the frame is valid.
- Replaces the direct datapath-to-memory instruction path; the datapath's pcen/ifid enable logic keys off ihit unchanged.

---
 rtl/icache_direct.sv | 118 +++++++++++
 tb/tb_icache_direct.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits from a frame array,
// single-word fills from memory on a miss while ihit is held low.
module icache_direct #(
  parameter int NSETS  = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              flush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic              dbg_state_o
);

  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = WORD_W - IDXW - 2;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] miss_addr_q, miss_addr_d;

  logic              valid_q [NSETS];
  logic [TAGW-1:0]   tag_q   [NSETS];
  logic [WORD_W-1:0] data_q  [NSETS];

  logic [TAGW-1:0] req_tag, fill_tag;
  logic [IDXW-1:0] req_idx, fill_idx;
  logic            hit;
  logic            fill_we;

  assign req_tag  = imemaddr[WORD_W-1:IDXW+2];
  assign req_idx  = imemaddr[IDXW+1:2];
  assign fill_tag = miss_addr_q[WORD_W-1:IDXW+2];
  assign fill_idx = miss_addr_q[IDXW+1:2];

  // Hit looks only at stored state, so a frame being filled this cycle still misses.
  assign hit     = imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_we = (state_q == FETCH) && !iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Flush has priority over a coincident fill: the filled frame stays invalid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NSETS; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NSETS; i++) begin
        if (flush) begin
          valid_q[i] <= 1'b0;
        end else if (fill_we && (fill_idx == IDXW'(i))) begin
          valid_q[i] <= 1'b1;
        end
        if (fill_we && (fill_idx == IDXW'(i))) begin
          tag_q[i]  <= fill_tag;
          data_q[i] <= iload;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit) begin
          state_d     = FETCH;
          miss_addr_d = imemaddr;
        end
      end
      FETCH: begin
        if (!iwait) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    dbg_state_o = (state_q == FETCH);
    case (state_q)
      IDLE: begin
        ihit     = hit;
        imemload = hit ? data_q[req_idx] : '0;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: latency-programmable memory model, per-scenario tasks,
// and an expected-data queue filled at fetch issue and drained at each hit.
module tb_icache_direct;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dbg_state_o;

  int checks;
  int failures;
  int mem_lat;
  int wait_cnt;
  logic [31:0] exp_q[$];

  icache_direct dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .dbg_state_o(dbg_state_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E3779B1 + 32'h3C010001;
  endfunction

  // Memory holds iwait high for mem_lat cycles of each request, then returns data.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) wait_cnt <= 0;
    else if (iREN && iwait) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign iwait = iREN && (wait_cnt < mem_lat);
  assign iload = mem_word(iaddr);

  task automatic do_reset();
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // Present one fetch at a negedge and sample #1 later each cycle until ihit.
  task automatic do_fetch(input logic [31:0] a, output int cyc, output logic [31:0] data,
                          output int ren_cyc, output int addr_err, output bit ok);
    cyc = 0; ren_cyc = 0; addr_err = 0; ok = 1'b0; data = '0;
    @(negedge CLK);
    imemaddr = a; imemREN = 1'b1;
    #1;
    for (int k = 0; k < 64; k++) begin
      if (iREN) begin
        ren_cyc++;
        if (iaddr !== a) addr_err++;
      end
      if (ihit) begin
        ok = 1'b1; data = imemload;
        break;
      end
      @(negedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (ihit !== 1'b0 || imemload !== 32'h0 || iREN !== 1'b0 || iaddr !== 32'h0 || dbg_state_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs ihit=%b imemload=%h iREN=%b iaddr=%h state=%b, required all zero",
               ihit, imemload, iREN, iaddr, dbg_state_o);
    end
  endtask

  task automatic test_first_miss();
    int cyc, ren_cyc, addr_err; logic [31:0] data, exp; bit ok;
    do_reset();
    mem_lat = 3;
    exp_q.push_back(32'h3C010001);
    do_fetch(32'h0, cyc, data, ren_cyc, addr_err, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || cyc != 5 || data !== exp) begin
      failures++;
      $display("FAIL first_miss ok=%0d hit_cycle=%0d data=%h, required hit_cycle=5 data=%h", ok, cyc, data, exp);
    end
    checks++;
    if (ren_cyc != 4 || addr_err != 0) begin
      failures++;
      $display("FAIL first_miss_iren iREN_cycles=%0d bad_iaddr=%0d, required 4 and 0", ren_cyc, addr_err);
    end
    exp_q.push_back(32'h3C010001);
    do_fetch(32'h0, cyc, data, ren_cyc, addr_err, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || cyc != 0 || data !== exp) begin
      failures++;
      $display("FAIL refetch_hit ok=%0d latency=%0d data=%h, required 0 and %h", ok, cyc, data, exp);
    end
  endtask

  task automatic test_sequential();
    int cyc, ren_cyc, addr_err; logic [31:0] data, exp; bit ok;
    do_reset();
    for (int w = 0; w < 16; w++) begin
      mem_lat = $urandom_range(0, 3);
      exp_q.push_back(mem_word(32'(w * 4)));
      do_fetch(32'(w * 4), cyc, data, ren_cyc, addr_err, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || cyc != mem_lat + 2 || data !== exp || addr_err != 0) begin
        failures++;
        $display("FAIL cold_word addr=%h ok=%0d latency=%0d data=%h, required latency=%0d data=%h",
                 w * 4, ok, cyc, data, mem_lat + 2, exp);
      end
    end
    for (int w = 0; w < 16; w++) begin
      exp_q.push_back(mem_word(32'(w * 4)));
      do_fetch(32'(w * 4), cyc, data, ren_cyc, addr_err, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || cyc != 0 || ren_cyc != 0 || data !== exp) begin
        failures++;
        $display("FAIL replay_word addr=%h latency=%0d iREN_cycles=%0d data=%h, required 0 0 %h",
                 w * 4, cyc, ren_cyc, data, exp);
      end
    end
  endtask

  task automatic test_conflict();
    int cyc, ren_cyc, addr_err; logic [31:0] data, exp; bit ok;
    do_reset();
    mem_lat = 1;
    do_fetch(32'h04, cyc, data, ren_cyc, addr_err, ok);
    do_fetch(32'h44, cyc, data, ren_cyc, addr_err, ok);
    exp_q.push_back(mem_word(32'h04));
    do_fetch(32'h04, cyc, data, ren_cyc, addr_err, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || cyc == 0 || ren_cyc == 0 || addr_err != 0 || data !== exp) begin
      failures++;
      $display("FAIL conflict_refetch latency=%0d iREN_cycles=%0d bad_iaddr=%0d data=%h, required miss at 0x04 data=%h",
               cyc, ren_cyc, addr_err, data, exp);
    end
    exp_q.push_back(mem_word(32'h44));
    do_fetch(32'h44, cyc, data, ren_cyc, addr_err, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || cyc == 0 || data !== exp) begin
      failures++;
      $display("FAIL conflict_evicted latency=%0d data=%h, required a miss and data=%h", cyc, data, exp);
    end
  endtask

  task automatic test_redirect();
    int cyc, ren_cyc, addr_err, bad; logic [31:0] data, exp; bit ok, done;
    do_reset();
    mem_lat = 4; bad = 0; done = 1'b0;
    @(negedge CLK);
    imemaddr = 32'h10; imemREN = 1'b1;
    @(negedge CLK);
    imemaddr = 32'h80;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!iREN) begin done = 1'b1; break; end
      if (iaddr !== 32'h10) bad++;
      @(negedge CLK);
    end
    checks++;
    if (!done || bad != 0 || ihit !== 1'b0) begin
      failures++;
      $display("FAIL redirect_fill done=%0d bad_iaddr=%0d ihit=%b, required 1 0 0", done, bad, ihit);
    end
    @(negedge CLK); #1;
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h80) begin
      failures++;
      $display("FAIL redirect_new_miss iREN=%b iaddr=%h, required 1 00000080", iREN, iaddr);
    end
    do_fetch(32'h80, cyc, data, ren_cyc, addr_err, ok);
    exp_q.push_back(mem_word(32'h10));
    do_fetch(32'h10, cyc, data, ren_cyc, addr_err, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || cyc != 0 || data !== exp) begin
      failures++;
      $display("FAIL redirect_old_hit latency=%0d data=%h, required 0 %h", cyc, data, exp);
    end
  endtask

  task automatic test_flush();
    int cyc, ren_cyc, addr_err; logic [31:0] data, exp; bit ok, found;
    do_reset();
    mem_lat = 1;
    do_fetch(32'h00, cyc, data, ren_cyc, addr_err, ok);
    do_fetch(32'h08, cyc, data, ren_cyc, addr_err, ok);
    @(negedge CLK);
    imemREN = 1'b0; flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    exp_q.push_back(mem_word(32'h00));
    do_fetch(32'h00, cyc, data, ren_cyc, addr_err, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || cyc == 0 || ren_cyc == 0 || data !== exp) begin
      failures++;
      $display("FAIL flush_miss latency=%0d iREN_cycles=%0d data=%h, required a miss data=%h", cyc, ren_cyc, data, exp);
    end
    // Flush in an IDLE hit cycle: the hit stands, the next cycle misses.
    @(negedge CLK);
    flush = 1'b1; #1;
    checks++;
    if (ihit !== 1'b1 || imemload !== mem_word(32'h00)) begin
      failures++;
      $display("FAIL flush_same_cycle_hit ihit=%b data=%h, required 1 %h", ihit, imemload, mem_word(32'h00));
    end
    @(negedge CLK);
    flush = 1'b0; #1;
    checks++;
    if (ihit !== 1'b0) begin
      failures++;
      $display("FAIL flush_next_cycle ihit=%b, required 0", ihit);
    end
    do_fetch(32'h00, cyc, data, ren_cyc, addr_err, ok);
    // Flush exactly in the fill cycle leaves the frame invalid.
    mem_lat = 2; found = 1'b0;
    @(negedge CLK);
    imemaddr = 32'h20; imemREN = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK); #1;
      if (iREN && !iwait) begin flush = 1'b1; found = 1'b1; break; end
    end
    @(negedge CLK);
    flush = 1'b0; #1;
    checks++;
    if (!found || ihit !== 1'b0) begin
      failures++;
      $display("FAIL flush_fill_cycle found=%0d ihit=%b, required 1 0", found, ihit);
    end
    @(negedge CLK); #1;
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h20) begin
      failures++;
      $display("FAIL flush_fill_refetch iREN=%b iaddr=%h, required 1 00000020", iREN, iaddr);
    end
    do_fetch(32'h20, cyc, data, ren_cyc, addr_err, ok);
  endtask

  task automatic test_async_reset();
    int cyc, ren_cyc, addr_err; logic [31:0] data, exp; bit ok;
    do_reset();
    mem_lat = 1;
    do_fetch(32'h0C, cyc, data, ren_cyc, addr_err, ok);
    mem_lat = 5;
    @(negedge CLK);
    imemaddr = 32'h30; imemREN = 1'b1;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++;
    if (iREN !== 1'b1 || iaddr !== 32'h30) begin
      failures++;
      $display("FAIL areset_precond iREN=%b iaddr=%h, required 1 00000030", iREN, iaddr);
    end
    #1;
    nRST = 1'b0;
    #1;
    checks++;
    if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'h0) begin
      failures++;
      $display("FAIL areset_immediate iREN=%b ihit=%b iaddr=%h, required 0 0 0", iREN, ihit, iaddr);
    end
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    mem_lat = 1;
    exp_q.push_back(mem_word(32'h0C));
    do_fetch(32'h0C, cyc, data, ren_cyc, addr_err, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || cyc == 0 || data !== exp) begin
      failures++;
      $display("FAIL areset_cold latency=%0d data=%h, required a miss data=%h", cyc, data, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0; mem_lat = 0;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0;
    test_reset();
    test_first_miss();
    test_sequential();
    test_conflict();
    test_redirect();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
